iot_src: RTL

IOT_SRC -- requirements
Module: iot_src

---
 rtl/iot_src_pkg.sv | 25 ++
 rtl/iot_res_cap.sv | 40 ++++
 rtl/iot_src.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/iot_src_pkg.sv
// iot_src_pkg
// Shared definitions for the IoT record source: FSM state encoding,
// consumer function codes and record geometry constants.
package iot_src_pkg;

    // Sequencer states: waiting for a record, or streaming its bytes out.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Function codes understood by the downstream consumer.
    localparam logic [2:0] FN_MAX     = 3'd1;
    localparam logic [2:0] FN_MIN     = 3'd2;
    localparam logic [2:0] FN_AVG     = 3'd3;
    localparam logic [2:0] FN_EXTRACT = 3'd4;
    localparam logic [2:0] FN_EXCLUDE = 3'd5;
    localparam logic [2:0] FN_PEAKMAX = 3'd6;
    localparam logic [2:0] FN_PEAKMIN = 3'd7;

    // Record geometry: one record is sixteen bytes, most significant first.
    localparam int BYTES_PER_REC = 16;
    localparam int REC_WIDTH     = 128;

endpackage

// File: rtl/iot_res_cap.sv
// iot_res_cap
// Captures consumer results independently of the byte sequencer.
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   valid, iot_out  consumer result strobe and 128-bit result
//   res_valid       one-cycle pulse when a result has been captured
//   res_data        most recently captured result, held between captures
//   res_cnt         number of captured results, saturating at 255
module iot_res_cap
    import iot_src_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [REC_WIDTH-1:0] iot_out,
    output logic                 res_valid,
    output logic [REC_WIDTH-1:0] res_data,
    output logic [7:0]           res_cnt
);

    // Every consumer strobe latches the result and pulses res_valid for a
    // single cycle; the counter stops at its all-ones value rather than
    // wrapping so software can tell "many" from "few".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_cnt   <= '0;
        end else begin
            res_valid <= valid;
            if (valid) begin
                res_data <= iot_out;
                if (res_cnt != 8'hFF) begin
                    res_cnt <= res_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/iot_src.sv
// iot_src
// Accepts 128-bit records from upstream and streams them byte by byte
// (most significant byte first) to an IoT consumer, honouring consumer
// backpressure. Records are grouped into rounds of REC_PER_ROUND; the
// function code is latched once per round. Consumer results are captured
// by the iot_res_cap sub-module.
// Ports:
//   clk, rst              clock and asynchronous active-low reset
//   fn_cfg                host function code, sampled at round start
//   rec_valid/rec_ready   record handshake, rec_data the record
//   busy                  consumer backpressure, blocks byte issue
//   in_en, iot_in         registered byte strobe and byte
//   fn_sel                registered function code, constant per round
//   valid, iot_out        consumer result strobe and result
//   res_valid/data/cnt    captured result pulse, value and count
//   round_done            pulse with the final byte of a round
module iot_src
    import iot_src_pkg::*;
#(
    parameter int REC_PER_ROUND = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           fn_cfg,
    input  logic                 rec_valid,
    input  logic [REC_WIDTH-1:0] rec_data,
    output logic                 rec_ready,
    input  logic                 busy,
    output logic                 in_en,
    output logic [7:0]           iot_in,
    output logic [2:0]           fn_sel,
    input  logic                 valid,
    input  logic [REC_WIDTH-1:0] iot_out,
    output logic                 res_valid,
    output logic [REC_WIDTH-1:0] res_data,
    output logic [7:0]           res_cnt,
    output logic                 round_done
);

    localparam int                RC_W      = (REC_PER_ROUND > 1) ? $clog2(REC_PER_ROUND) : 1;
    localparam logic [RC_W-1:0]   LAST_REC  = RC_W'(REC_PER_ROUND - 1);
    localparam logic [3:0]        LAST_BYTE = 4'(BYTES_PER_REC - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [REC_WIDTH-1:0]   shreg;
    logic [3:0]             byte_cnt;
    logic [RC_W-1:0]        rec_cnt;
    logic [RC_W-1:0]        rec_cnt_nxt;
    logic                   issue;
    logic                   last_byte;
    logic                   accept;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode. While sending, a new record may only
    // be taken on the edge that issues the final byte of the current one,
    // which keeps the byte stream gapless without ever overwriting bytes
    // that still need to go out.
    always_comb begin
        state_nxt = state;
        rec_ready = 1'b0;
        issue     = 1'b0;
        last_byte = 1'b0;
        case (state)
            IDLE: begin
                rec_ready = 1'b1;
                if (rec_valid) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                issue     = !busy;
                last_byte = !busy && (byte_cnt == LAST_BYTE);
                rec_ready = last_byte;
                if (last_byte && !rec_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = rec_valid && rec_ready;

    // Record counter after this edge; a record accepted together with the
    // last byte of a round must see the wrapped value so it opens the new
    // round and picks up a fresh function code.
    always_comb begin
        rec_cnt_nxt = rec_cnt;
        if (last_byte) begin
            rec_cnt_nxt = (rec_cnt == LAST_REC) ? '0 : rec_cnt + RC_W'(1);
        end
    end

    // Byte datapath. An accept in the same edge as the final byte overrides
    // the shift so the new record is loaded intact.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg      <= '0;
            byte_cnt   <= '0;
            rec_cnt    <= '0;
            in_en      <= 1'b0;
            iot_in     <= '0;
            fn_sel     <= '0;
            round_done <= 1'b0;
        end else begin
            in_en      <= issue;
            round_done <= last_byte && (rec_cnt == LAST_REC);
            rec_cnt    <= rec_cnt_nxt;
            if (issue) begin
                iot_in   <= shreg[REC_WIDTH-1 -: 8];
                shreg    <= {shreg[REC_WIDTH-9:0], 8'h00};
                byte_cnt <= byte_cnt + 4'd1;
            end
            if (accept) begin
                shreg    <= rec_data;
                byte_cnt <= '0;
                if (rec_cnt_nxt == '0) begin
                    fn_sel <= fn_cfg;
                end
            end
        end
    end

    iot_res_cap u_res_cap (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .iot_out   (iot_out),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_cnt   (res_cnt)
    );

endmodule
